// File: rtl/prog_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : prog_sequencer
// Purpose  : Multi-cycle instruction sequencer for the 9-bit-ISA core. Owns
//            the program counter, accepts the Start handshake and decides each
//            cycle whether the decoded instruction commits, advances,
//            branches, stalls for a data-memory load, or halts.
// Ports    : Clk, Reset       - clock (rising edge), async active-high reset
//            Start, StartAddr - launch request (IDLE/HALT only) and entry PC
//            Jen, BrTaken     - decoded branch and ALU condition flag
//            Jtarget          - absolute branch target
//            RenD, DoneIn     - decoded load and halt instructions
//            ProgCtr          - instruction ROM address (registered)
//            InstEn           - commit strobe gating regfile/memory writes
//            Busy             - high while executing (RUN or WAIT)
//            Done             - registered, high in HALT
//            CycleCnt         - executed-cycle counter
// Options  : SEQ_CYCLE_COUNT_EN - when defined, CycleCnt counts RUN/WAIT
//            clocks (saturating); otherwise it is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module prog_sequencer #(
    parameter int PC_W     = 10,
    parameter int LOAD_LAT = 1
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic [PC_W-1:0] StartAddr,
    input  logic            Jen,
    input  logic            BrTaken,
    input  logic [PC_W-1:0] Jtarget,
    input  logic            RenD,
    input  logic            DoneIn,
    output logic [PC_W-1:0] ProgCtr,
    output logic            InstEn,
    output logic            Busy,
    output logic            Done,
    output logic [15:0]     CycleCnt
);

    // Wait counter must hold LOAD_LAT; keep at least one bit when LOAD_LAT=0.
    localparam int CNT_W = (LOAD_LAT < 1) ? 1 : $clog2(LOAD_LAT + 1);
    localparam logic [CNT_W-1:0] c_LOAD_LAT = CNT_W'(LOAD_LAT);
    localparam logic [CNT_W-1:0] c_WAIT_ONE = CNT_W'(1);
    localparam bit               c_HAS_LAT  = (LOAD_LAT > 0);

    typedef enum logic [1:0] {
        c_IDLE = 2'd0,
        c_RUN  = 2'd1,
        c_WAIT = 2'd2,
        c_HALT = 2'd3
    } state_t;

    state_t           r_state;
    logic [PC_W-1:0]  r_pc;
    logic             r_done;
    logic [CNT_W-1:0] r_wait_cnt;

    logic w_load_stall;
    logic w_start_acc;
    logic w_inst_en;
    logic w_busy;

    // A load only stalls when the memory actually needs extra cycles.
    assign w_load_stall = RenD && c_HAS_LAT;
    assign w_start_acc  = Start && ((r_state == c_IDLE) || (r_state == c_HALT));

    always_comb begin
        w_inst_en = 1'b0;
        w_busy    = 1'b0;
        case (r_state)
            c_RUN: begin
                w_busy    = 1'b1;
                // Halt and stalled loads do not commit in their RUN cycle.
                w_inst_en = !DoneIn && !w_load_stall;
            end
            c_WAIT: begin
                w_busy    = 1'b1;
                // Load writeback commits in the final wait cycle.
                w_inst_en = (r_wait_cnt == c_WAIT_ONE);
            end
            default: begin
                w_inst_en = 1'b0;
                w_busy    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= c_IDLE;
            r_pc       <= '0;
            r_done     <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (Start) begin
                        r_pc    <= StartAddr;
                        r_state <= c_RUN;
                    end
                end
                c_RUN: begin
                    if (DoneIn) begin
                        r_done  <= 1'b1;
                        r_state <= c_HALT;
                    end else if (w_load_stall) begin
                        // RenD outranks Jen, so an illegal load+branch stalls.
                        r_wait_cnt <= c_LOAD_LAT;
                        r_state    <= c_WAIT;
                    end else if (Jen && BrTaken) begin
                        r_pc <= Jtarget;
                    end else begin
                        r_pc <= r_pc + PC_W'(1);
                    end
                end
                c_WAIT: begin
                    if (r_wait_cnt == c_WAIT_ONE) begin
                        r_pc       <= r_pc + PC_W'(1);
                        r_wait_cnt <= '0;
                        r_state    <= c_RUN;
                    end else if (r_wait_cnt == '0) begin
                        // Unreachable in normal flow; recover without a commit.
                        r_state <= c_RUN;
                    end else begin
                        r_wait_cnt <= r_wait_cnt - CNT_W'(1);
                    end
                end
                c_HALT: begin
                    if (Start) begin
                        r_done  <= 1'b0;
                        r_pc    <= StartAddr;
                        r_state <= c_RUN;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

`ifdef SEQ_CYCLE_COUNT_EN
    logic [15:0] r_cycle_cnt;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_cycle_cnt <= '0;
        end else if (w_start_acc) begin
            r_cycle_cnt <= '0;
        end else if (w_busy && (r_cycle_cnt != 16'hFFFF)) begin
            r_cycle_cnt <= r_cycle_cnt + 16'd1;
        end
    end

    assign CycleCnt = r_cycle_cnt;
`else
    // Start acceptance only feeds the counter; keep it referenced.
    logic w_unused_start;
    assign w_unused_start = w_start_acc;
    assign CycleCnt       = 16'd0;
`endif

    assign ProgCtr = r_pc;
    assign Done    = r_done;
    assign InstEn  = w_inst_en;
    assign Busy    = w_busy;

endmodule
`default_nettype wire

// File: tb/tb_prog_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_sequencer
// Purpose  : Directed-vector bench for prog_sequencer (PC_W=10, LOAD_LAT=2).
//            Each step drives one cycle of inputs and queues the outputs
//            expected during that cycle; a monitor pops and compares them on
//            the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_sequencer;

    localparam int PC_W = 10;

    logic            Clk = 1'b0;
    logic            Reset;
    logic            Start;
    logic [PC_W-1:0] StartAddr;
    logic            Jen;
    logic            BrTaken;
    logic [PC_W-1:0] Jtarget;
    logic            RenD;
    logic            DoneIn;
    logic [PC_W-1:0] ProgCtr;
    logic            InstEn;
    logic            Busy;
    logic            Done;
    logic [15:0]     CycleCnt;

    prog_sequencer #(.PC_W(PC_W), .LOAD_LAT(2)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Start     (Start),
        .StartAddr (StartAddr),
        .Jen       (Jen),
        .BrTaken   (BrTaken),
        .Jtarget   (Jtarget),
        .RenD      (RenD),
        .DoneIn    (DoneIn),
        .ProgCtr   (ProgCtr),
        .InstEn    (InstEn),
        .Busy      (Busy),
        .Done      (Done),
        .CycleCnt  (CycleCnt)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        int              id;
        logic [PC_W-1:0] pc;
        logic            ie;
        logic            busy;
        logic            done;
        logic [15:0]     cc;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   step_id = 0;

    function automatic logic [15:0] ccx(input int n);
`ifdef SEQ_CYCLE_COUNT_EN
        return 16'(n);
`else
        return 16'd0 + 16'(n - n);
`endif
    endfunction

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL step%0d %s: got %h want %h", id, name, act, want);
        end
    endtask

    // Monitor: compares whatever the DUT shows mid-cycle against the queue.
    always @(negedge Clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("ProgCtr",  e.id, 32'(ProgCtr),  32'(e.pc));
            chk("InstEn",   e.id, 32'(InstEn),   32'(e.ie));
            chk("Busy",     e.id, 32'(Busy),     32'(e.busy));
            chk("Done",     e.id, 32'(Done),     32'(e.done));
            chk("CycleCnt", e.id, 32'(CycleCnt), 32'(e.cc));
        end
    end

    // One cycle: drive inputs just after the rising edge, queue expectations.
    task automatic step(input logic rst, input logic st, input logic [PC_W-1:0] sa,
                        input logic jn, input logic br, input logic [PC_W-1:0] jt,
                        input logic rd, input logic dn,
                        input logic [PC_W-1:0] epc, input logic eie, input logic ebusy,
                        input logic edone, input logic [15:0] ecc);
        exp_t e;
        @(posedge Clk);
        #1;
        Reset = rst; Start = st; StartAddr = sa;
        Jen = jn; BrTaken = br; Jtarget = jt; RenD = rd; DoneIn = dn;
        step_id++;
        e.id = step_id; e.pc = epc; e.ie = eie; e.busy = ebusy; e.done = edone; e.cc = ecc;
        q.push_back(e);
    endtask

    initial begin
        Reset = 1'b1; Start = 1'b0; StartAddr = '0; Jen = 1'b0; BrTaken = 1'b0;
        Jtarget = '0; RenD = 1'b0; DoneIn = 1'b0;
        //    rst st  sa      jn br jt      rd dn   pc      ie bsy dn  cc
        step(1, 0, 10'h000, 0, 0, 10'h000, 0, 0,  10'h000, 0, 0, 0, ccx(0));  // reset
        step(0, 0, 10'h000, 0, 0, 10'h000, 0, 0,  10'h000, 0, 0, 0, ccx(0));  // idle hold
        step(0, 1, 10'h005, 0, 0, 10'h000, 0, 0,  10'h000, 0, 0, 0, ccx(0));  // start @5
        step(0, 0, 10'h000, 0, 0, 10'h000, 0, 0,  10'h005, 1, 1, 0, ccx(0));
        step(0, 0, 10'h000, 0, 0, 10'h000, 0, 0,  10'h006, 1, 1, 0, ccx(1));
        step(0, 1, 10'h155, 0, 0, 10'h000, 0, 0,  10'h007, 1, 1, 0, ccx(2));  // Start ignored
        step(0, 0, 10'h000, 1, 1, 10'h020, 0, 0,  10'h008, 1, 1, 0, ccx(3));  // taken
        step(0, 0, 10'h000, 1, 1, 10'h008, 0, 0,  10'h020, 1, 1, 0, ccx(4));  // back to 8
        step(0, 0, 10'h000, 1, 0, 10'h020, 0, 0,  10'h008, 1, 1, 0, ccx(5));  // not taken
        step(0, 0, 10'h000, 1, 1, 10'h030, 0, 0,  10'h009, 1, 1, 0, ccx(6));
        step(0, 0, 10'h000, 0, 0, 10'h000, 1, 0,  10'h030, 0, 1, 0, ccx(7));  // load
        step(0, 0, 10'h000, 0, 0, 10'h000, 1, 0,  10'h030, 0, 1, 0, ccx(8));
        step(0, 0, 10'h000, 0, 0, 10'h000, 1, 0,  10'h030, 1, 1, 0, ccx(9));
        step(0, 0, 10'h000, 1, 1, 10'h200, 1, 0,  10'h031, 0, 1, 0, ccx(10)); // RenD beats Jen
        step(0, 0, 10'h000, 0, 0, 10'h000, 0, 0,  10'h031, 0, 1, 0, ccx(11));
        step(0, 0, 10'h000, 0, 0, 10'h000, 0, 0,  10'h031, 1, 1, 0, ccx(12));
        step(0, 0, 10'h000, 1, 1, 10'h3FF, 0, 0,  10'h032, 1, 1, 0, ccx(13));
        step(0, 0, 10'h000, 0, 0, 10'h000, 0, 0,  10'h3FF, 1, 1, 0, ccx(14)); // wrap
        step(0, 0, 10'h000, 1, 1, 10'h123, 0, 1,  10'h000, 0, 1, 0, ccx(15)); // halt wins
        for (int i = 0; i < 5; i++)
            step(0, 0, 10'h000, 1, 1, 10'h123, 1, 1, 10'h000, 0, 0, 1, ccx(16));
        step(0, 1, 10'h100, 0, 0, 10'h000, 0, 0,  10'h000, 0, 0, 1, ccx(16)); // restart
        step(0, 0, 10'h000, 0, 0, 10'h000, 0, 0,  10'h100, 1, 1, 0, ccx(0));
        step(0, 0, 10'h000, 0, 0, 10'h000, 1, 0,  10'h101, 0, 1, 0, ccx(1));
        step(0, 0, 10'h000, 0, 0, 10'h000, 1, 0,  10'h101, 0, 1, 0, ccx(2));
        step(1, 0, 10'h000, 0, 0, 10'h000, 1, 0,  10'h000, 0, 0, 0, ccx(0));  // async reset
        step(0, 1, 10'h3FE, 0, 0, 10'h000, 0, 0,  10'h000, 0, 0, 0, ccx(0));
        step(0, 0, 10'h000, 0, 0, 10'h000, 0, 0,  10'h3FE, 1, 1, 0, ccx(0));
        step(0, 0, 10'h000, 0, 0, 10'h000, 0, 0,  10'h3FF, 1, 1, 0, ccx(1));
        step(0, 0, 10'h000, 0, 0, 10'h000, 0, 0,  10'h000, 1, 1, 0, ccx(2));
        step(0, 0, 10'h000, 0, 0, 10'h000, 0, 0,  10'h001, 1, 1, 0, ccx(3));
        step(0, 0, 10'h000, 0, 0, 10'h000, 0, 1,  10'h002, 0, 1, 0, ccx(4));
        step(0, 0, 10'h000, 0, 0, 10'h000, 0, 0,  10'h002, 0, 0, 1, ccx(5));
        step(0, 0, 10'h000, 0, 0, 10'h000, 0, 0,  10'h002, 0, 0, 1, ccx(5));
        step(0, 1, 10'h010, 0, 0, 10'h000, 0, 0,  10'h002, 0, 0, 1, ccx(5));
        step(0, 0, 10'h000, 0, 0, 10'h000, 0, 0,  10'h010, 1, 1, 0, ccx(0));
        @(negedge Clk);
        #1;
        // Every queued expectation must have been consumed by the monitor.
        chk("queue_drained", step_id, 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
Multi-cycle instruction sequencer for the 9-bit-ISA core. It owns the program counter and accepts the Start handshake from the testbench or top level. It decides each cycle whether the decoded instruction commits, advances, branches, stalls for a data-memory load, or halts. It sits between the instruction ROM (drives its address) and the decoder/datapath (consumes Jen, RenD and Done decode outputs plus the ALU branch flag, and gates register-file and data-memory writes).

Parameters:
PC_W, 10, program counter width; instruction ROM depth is 2**PC_W.
LOAD_LAT, 1, extra cycles a data-memory read needs before writeback; 0 means a load commits in a single cycle like any other instruction.

Ports:
Clk  input  1  system clock, rising edge.
Reset  input  1  asynchronous, active-high reset.
Start  input  1  level; sampled in IDLE/HALT only; begins execution.
StartAddr  input  PC_W  first instruction address, captured when Start is accepted.
Jen  input  1  decoded branch instruction.
BrTaken  input  1  ALU condition flag; a branch is taken only if Jen and BrTaken are both 1.
Jtarget  input  PC_W  absolute branch target from the jump lookup.
RenD  input  1  decoded load instruction.
DoneIn  input  1  decoded halt instruction.
ProgCtr  output  PC_W  instruction ROM address (registered).
InstEn  output  1  commit strobe; the datapath may write regs or memory only when it is 1.
Busy  output  1  high in RUN or WAIT.
Done  output  1  registered; high in HALT.
CycleCnt  output  16  executed-cycle counter (see Optional Feature).

Behaviour:
- Reset (async, any state):
  - state=IDLE, ProgCtr=0, Done=0, wait counter=0, CycleCnt=0.
  - InstEn=0 and Busy=0 follow from state.
- States: IDLE, RUN, WAIT, HALT. All state and PC updates occur on the rising edge of Clk.
- IDLE:
  - Start=1 → ProgCtr<=StartAddr, go to RUN.
  - Start=0 → hold.
- RUN: one instruction per cycle. Priority, highest first:
  1. DoneIn=1 → InstEn=0, ProgCtr holds, Done<=1, go to HALT.
  2. RenD=1 and LOAD_LAT>0 → InstEn=0, ProgCtr holds, wait counter<=LOAD_LAT, go to WAIT.
  3. Jen=1 and BrTaken=1 → InstEn=1, ProgCtr<=Jtarget.
  4. Otherwise → InstEn=1, ProgCtr<=ProgCtr+1.
- RUN notes:
  - Jen=1 with BrTaken=0 is an ordinary increment; InstEn=1 (branches write nothing anyway).
  - RenD=1 with LOAD_LAT=0 follows rule 4.
  - If RenD and Jen are both 1 (illegal decode), RenD wins.
- WAIT:
  - ProgCtr holds; the counter decrements each cycle.
  - Counter>1: InstEn=0.
  - Counter==1: InstEn=1 (load writeback commits), ProgCtr<=ProgCtr+1, go to RUN.
  - Total load cost is LOAD_LAT+1 cycles.
- HALT:
  - Done=1 and ProgCtr hold until Start=1.
  - Start=1 → Done<=0, ProgCtr<=StartAddr, go to RUN.
- Start while in RUN or WAIT is ignored.
- InstEn and Busy are combinational from state, counter and decode inputs. No other output is combinational.
- Arithmetic:
  - ProgCtr+1 wraps modulo 2**PC_W; 2**PC_W-1 → 0 with no flag.
  - Jtarget is used unmodified.
- Reset mid-operation (RUN/WAIT) discards the in-flight instruction. No commit strobe is issued in the reset cycle.

Optional Feature:
- Macro: SEQ_CYCLE_COUNT_EN.
- Defined:
  - CycleCnt increments by 1 on every clock spent in RUN or WAIT.
  - It saturates at 16'hFFFF, freezes in HALT and IDLE, and clears to 0 when Start is accepted.
- Undefined: CycleCnt is tied to 0 and no counter flops are inferred. The port list is identical in both builds.

Test Plan:
1. Reset, Start=1 with StartAddr=10'h005, no Jen/RenD/DoneIn for 3 cycles → ProgCtr sequence 5,6,7,8; InstEn=1 each RUN cycle; Busy=1.
2. At ProgCtr=8: Jen=1, BrTaken=1, Jtarget=10'h020 → next ProgCtr=0x020. Repeat with BrTaken=0 → ProgCtr=9.
3. LOAD_LAT=2, RenD=1 at ProgCtr=0x030 → InstEn sequence 0,0,1 over 3 cycles; ProgCtr stays 0x030, then 0x031.
4. ProgCtr=10'h3FF, plain instruction → ProgCtr=0. Then DoneIn=1 → Done=1 next cycle, ProgCtr frozen at 0 for 5 cycles.
5. In HALT, Start=1 with StartAddr=0x100 → Done=0 and ProgCtr=0x100 next cycle. Assert Reset asynchronously mid-WAIT → ProgCtr=0, Done=0, IDLE immediately, InstEn=0.
6. SEQ_CYCLE_COUNT_EN defined: program of 4 plain instructions then halt → CycleCnt=5 held in HALT, cleared to 0 on next Start. Undefined → CycleCnt=0 throughout.
